// File: rtl/wb_regfile_if.sv
// wb_regfile_if: write-back / register-file bus of the MIPS pipeline.
// The master drives the MEM/WB write-back fields, the operand read addresses
// and the debug address; the slave (wb_regfile) returns read data and the
// selected write-back value.
interface wb_regfile_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [DW-1:0] WB_DataMem;
  logic [DW-1:0] WB_Alu_C;
  logic          WB_Reg_Src;
  logic          WB_RegW;
  logic [AW-1:0] WB_WBdst;
  logic [AW-1:0] ID_Rs_addr;
  logic [AW-1:0] ID_Rt_addr;
  logic [DW-1:0] ID_Rs_data;
  logic [DW-1:0] ID_Rt_data;
  logic [DW-1:0] WB_WrData;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  modport master (
    output WB_DataMem, WB_Alu_C, WB_Reg_Src, WB_RegW, WB_WBdst,
    output ID_Rs_addr, ID_Rt_addr, dbg_addr,
    input  ID_Rs_data, ID_Rt_data, WB_WrData, dbg_data
  );

  modport slave (
    input  WB_DataMem, WB_Alu_C, WB_Reg_Src, WB_RegW, WB_WBdst,
    input  ID_Rs_addr, ID_Rt_addr, dbg_addr,
    output ID_Rs_data, ID_Rt_data, WB_WrData, dbg_data
  );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: write-back select and 2**AW-entry register file, $0 hardwired
// to zero, two combinational operand read ports plus a debug read port.
// Optional macro WB_RF_BYPASS_EN: when defined, operand ports A/B forward the
// value being committed this cycle (write-before-read); the debug port never
// forwards. When undefined, a colliding read returns the old array contents.
module wb_regfile #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] regs [DEPTH];
  logic [DW-1:0] wr_data;
  logic          commit;

  // Write-back source select and commit qualification; nothing commits
  // (or forwards) while reset is held.
  always_comb begin
    wr_data = bus.WB_Reg_Src ? bus.WB_DataMem : bus.WB_Alu_C;
    commit  = bus.WB_RegW && (bus.WB_WBdst != '0) && !rst;
  end

  assign bus.WB_WrData = wr_data;

  // Register array: async clear, one write per rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[bus.WB_WBdst] <= wr_data;
    end
  end

  // Operand port A: $0 forced to zero, optional same-cycle forward.
  always_comb begin
    bus.ID_Rs_data = regs[bus.ID_Rs_addr];
`ifdef WB_RF_BYPASS_EN
    if (commit && (bus.ID_Rs_addr == bus.WB_WBdst)) begin
      bus.ID_Rs_data = wr_data;
    end
`endif
    if (bus.ID_Rs_addr == '0) begin
      bus.ID_Rs_data = '0;
    end
  end

  // Operand port B: same rules as port A.
  always_comb begin
    bus.ID_Rt_data = regs[bus.ID_Rt_addr];
`ifdef WB_RF_BYPASS_EN
    if (commit && (bus.ID_Rt_addr == bus.WB_WBdst)) begin
      bus.ID_Rt_data = wr_data;
    end
`endif
    if (bus.ID_Rt_addr == '0) begin
      bus.ID_Rt_data = '0;
    end
  end

  // Debug port: array contents only, $0 forced to zero.
  always_comb begin
    bus.dbg_data = regs[bus.dbg_addr];
    if (bus.dbg_addr == '0) begin
      bus.dbg_data = '0;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed stimulus with literal expectations, plus a
// behavioural register-file model checked against the DUT on every falling
// clock edge.
module tb_wb_regfile;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_regfile_if #(.DW(32), .AW(5)) bus ();

  wb_regfile #(.DW(32), .AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] model [32];

  function automatic logic [31:0] m_wr();
    return bus.WB_Reg_Src ? bus.WB_DataMem : bus.WB_Alu_C;
  endfunction

  function automatic logic m_commit();
    return bus.WB_RegW && (bus.WB_WBdst != 5'd0) && !rst;
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a, input bit fwd);
    if (a == 5'd0 || rst) return 32'h0;
    if (fwd && m_commit() && a == bus.WB_WBdst) return m_wr();
    return model[a];
  endfunction

`ifdef WB_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (m_commit()) begin
      model[bus.WB_WBdst] = m_wr();
    end
  end

  always @(negedge clk) begin
    chk("m_wrdata", bus.WB_WrData, m_wr());
    chk("m_rs",     bus.ID_Rs_data, m_rd(bus.ID_Rs_addr, BYP));
    chk("m_rt",     bus.ID_Rt_data, m_rd(bus.ID_Rt_addr, BYP));
    chk("m_dbg",    bus.dbg_data,   m_rd(bus.dbg_addr, 1'b0));
  end

  // ---------------- directed stimulus ----------------
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.WB_DataMem = '0; bus.WB_Alu_C = '0; bus.WB_Reg_Src = 1'b0;
    bus.WB_RegW = 1'b0; bus.WB_WBdst = '0;
    bus.ID_Rs_addr = '0; bus.ID_Rt_addr = '0; bus.dbg_addr = '0;

    // Reset state
    repeat (2) edge_step();
    bus.dbg_addr = 5'd5; bus.ID_Rs_addr = 5'd5;
    #1 chk("reset_rs5", bus.ID_Rs_data, 32'h0);
    rst = 1'b0;

    // Write reg 5, then async reset clears it before any edge
    bus.WB_RegW = 1'b1; bus.WB_WBdst = 5'd5; bus.WB_Alu_C = 32'h1234_5678;
    edge_step();
    bus.WB_RegW = 1'b0;
    #1 chk("wr_rs5", bus.ID_Rs_data, 32'h1234_5678);
    rst = 1'b1;
    #1 chk("async_rst_rs5", bus.ID_Rs_data, 32'h0);
    chk("async_rst_dbg5", bus.dbg_data, 32'h0);
    edge_step();
    rst = 1'b0;

    // Source select
    bus.WB_Alu_C = 32'hAAAA_0001; bus.WB_DataMem = 32'h5555_0002;
    bus.WB_Reg_Src = 1'b1; bus.WB_RegW = 1'b1; bus.WB_WBdst = 5'd7;
    #1 chk("wrdata_mem", bus.WB_WrData, 32'h5555_0002);
    edge_step();
    bus.WB_Reg_Src = 1'b0; bus.WB_WBdst = 5'd8; bus.dbg_addr = 5'd7;
    #1 chk("wrdata_alu", bus.WB_WrData, 32'hAAAA_0001);
    chk("reg7", bus.dbg_data, 32'h5555_0002);
    edge_step();
    bus.WB_RegW = 1'b0; bus.dbg_addr = 5'd8;
    #1 chk("reg8", bus.dbg_data, 32'hAAAA_0001);

    // $0 protection
    bus.WB_RegW = 1'b1; bus.WB_WBdst = 5'd0; bus.WB_Alu_C = 32'hDEAD_BEEF;
    bus.ID_Rs_addr = 5'd0; bus.ID_Rt_addr = 5'd0; bus.dbg_addr = 5'd0;
    #1 chk("r0_rs_pre", bus.ID_Rs_data, 32'h0);
    chk("r0_rt_pre", bus.ID_Rt_data, 32'h0);
    chk("r0_dbg_pre", bus.dbg_data, 32'h0);
    edge_step();
    bus.WB_RegW = 1'b0;
    #1 chk("r0_rs_post", bus.ID_Rs_data, 32'h0);
    chk("r0_rt_post", bus.ID_Rt_data, 32'h0);
    chk("r0_dbg_post", bus.dbg_data, 32'h0);

    // Write disable
    bus.WB_WBdst = 5'd9; bus.WB_Alu_C = 32'hFFFF_FFFF; bus.dbg_addr = 5'd9;
    edge_step();
    #1 chk("reg9_nowrite", bus.dbg_data, 32'h0);

    // Collision
    bus.WB_RegW = 1'b1; bus.WB_WBdst = 5'd10; bus.WB_Alu_C = 32'h0000_0011;
    edge_step();
    bus.WB_Alu_C = 32'h0000_0022;
    bus.ID_Rs_addr = 5'd10; bus.ID_Rt_addr = 5'd10; bus.dbg_addr = 5'd10;
    #1;
`ifdef WB_RF_BYPASS_EN
    chk("coll_rs_pre", bus.ID_Rs_data, 32'h0000_0022);
    chk("coll_rt_pre", bus.ID_Rt_data, 32'h0000_0022);
`else
    chk("coll_rs_pre", bus.ID_Rs_data, 32'h0000_0011);
    chk("coll_rt_pre", bus.ID_Rt_data, 32'h0000_0011);
`endif
    chk("coll_dbg_pre", bus.dbg_data, 32'h0000_0011);
    edge_step();
    bus.WB_RegW = 1'b0;
    #1 chk("coll_rs_post", bus.ID_Rs_data, 32'h0000_0022);
    chk("coll_rt_post", bus.ID_Rt_data, 32'h0000_0022);
    chk("coll_dbg_post", bus.dbg_data, 32'h0000_0022);

    // Back-to-back writes to regs 1..31
    bus.WB_Reg_Src = 1'b0; bus.WB_RegW = 1'b1;
    for (int k = 1; k < 32; k++) begin
      bus.WB_WBdst = 5'(k);
      bus.WB_Alu_C = 32'h100 + 32'(k);
      edge_step();
    end
    bus.WB_RegW = 1'b0;
    for (int k = 0; k < 32; k++) begin
      bus.dbg_addr = 5'(k);
      #1 chk($sformatf("sweep%0d", k), bus.dbg_data, (k == 0) ? 32'h0 : 32'h100 + 32'(k));
    end

    // Reset mid-operation: in-flight write to reg 3 is lost
    edge_step();
    bus.WB_RegW = 1'b1; bus.WB_WBdst = 5'd3; bus.WB_Alu_C = 32'h0000_0333;
    bus.dbg_addr = 5'd3; bus.ID_Rs_addr = 5'd3;
    #1 rst = 1'b1;
    #1 chk("midrst_dbg3", bus.dbg_data, 32'h0);
    chk("midrst_rs3", bus.ID_Rs_data, 32'h0);
    chk("midrst_wrdata", bus.WB_WrData, 32'h0000_0333);
    edge_step();
    bus.WB_RegW = 1'b0;
    rst = 1'b0;
    #1 chk("midrst_reg3_after", bus.dbg_data, 32'h0);
    edge_step();
    edge_step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and general-purpose register file of the 5-stage MIPS pipeline. Sits directly downstream of the MEM/WB pipeline register. Selects the write-back value (load data or ALU result), commits it to a 32-entry register file on the clock edge, and serves the two combinational operand read ports used by the ID stage plus one debug read port. Register $0 is hardwired to zero.

## Interface
Parameters:
- DW, 32, data width of every register and data port
- AW, 5, register address width; depth is 2**AW

Ports:
- clk  in  1  pipeline clock; all register writes on rising edge
- rst  in  1  reset, asynchronous, active-high
- WB_DataMem  in  DW  load data from the MEM/WB register
- WB_Alu_C  in  DW  ALU result from the MEM/WB register
- WB_Reg_Src  in  1  write-back source select: 1 = WB_DataMem, 0 = WB_Alu_C
- WB_RegW  in  1  register write enable
- WB_WBdst  in  AW  destination register number
- ID_Rs_addr  in  AW  read port A address
- ID_Rt_addr  in  AW  read port B address
- ID_Rs_data  out  DW  read port A data
- ID_Rt_data  out  DW  read port B data
- WB_WrData  out  DW  selected write-back value, exported to the EX forwarding mux
- dbg_addr  in  AW  debug read address
- dbg_data  out  DW  debug read data; never bypassed

## Operation
- WB_WrData = WB_Reg_Src ? WB_DataMem : WB_Alu_C; purely combinational, valid regardless of WB_RegW.
- Commit condition: WB_RegW == 1 and WB_WBdst != 0. On the rising clk edge when true, reg[WB_WBdst] <= WB_WrData. Otherwise no register changes.
- Writes addressed to $0 are silently discarded; reg[0] reads as 0 on every port at all times.
- Read ports A, B and debug are asynchronous (combinational from address and array contents).
- Read data for address 0 is forced to 0 independent of array contents and bypass.
- Reset: all 32 registers cleared to 0 asynchronously while rst is high; no writes commit while rst is high even if clk toggles. With rst high, ID_Rs_data, ID_Rt_data, dbg_data read 0; WB_WrData still follows its inputs (combinational).
- Reset asserted mid-operation: any in-flight write in that cycle is lost; array reads 0 immediately after rst rises.
- A and B may address the same register; both return the same value.

## Timing
- Write latency: 1 edge. Value presented on cycle N with commit condition is visible on non-bypassed reads from cycle N+1.
- Read latency: 0 cycles (combinational).
- WB_WrData: 0-cycle combinational path from WB_* inputs.
- Same-cycle read/write collision behaviour is set by the configuration macro below.
- No handshake; block never stalls and accepts one write per cycle.

## Configuration
- WB_RF_BYPASS_EN defined: on ports A and B, if commit condition is true and read address == WB_WBdst, output WB_WrData in the same cycle (write-before-read). Removes the 3-cycle RAW hazard between WB and ID. dbg_data unaffected.
- WB_RF_BYPASS_EN undefined: ports A and B return array contents only; a colliding read returns the old value until the next edge. The hazard unit must then stall ID one extra cycle for a WB→ID dependency.

## Test plan
- Reset: drive rst=1 after writing reg 5 = 0x1234_5678 -> ID_Rs_data with ID_Rs_addr=5 reads 0x0000_0000 immediately, before any clk edge.
- Source select: WB_Alu_C=0xAAAA_0001, WB_DataMem=0x5555_0002, WB_Reg_Src=1, RegW=1, dst=7 -> WB_WrData=0x5555_0002; after edge reg 7 = 0x5555_0002; repeat with Reg_Src=0, dst=8 -> reg 8 = 0xAAAA_0001.
- $0 protection: RegW=1, dst=0, data 0xDEAD_BEEF -> ID_Rs_data, ID_Rt_data, dbg_data at address 0 all read 0 before and after edge.
- Write-disable: RegW=0, dst=9, data 0xFFFF_FFFF -> reg 9 keeps prior value 0x0000_0000.
- Collision: reg 10 holds 0x0000_0011; same cycle RegW=1, dst=10, data 0x0000_0022, ID_Rs_addr=ID_Rt_addr=10 -> with WB_RF_BYPASS_EN both ports 0x0000_0022 before edge; without it 0x0000_0011 before edge, 0x0000_0022 after; dbg_data at 10 = 0x0000_0011 before edge in both builds.
- Back-to-back: writes to regs 1..31 on consecutive cycles with data = 0x100 + index -> debug sweep reads reg k = 0x100 + k for k=1..31, reg 0 = 0.
